// File: rtl/serial_xnor_comparator.sv
// serial_xnor_comparator: compares two LSB-first serial bit streams over a
// WIDTH-bit word, counts bit mismatches (per-bit XNOR equality) and reports
// the word result with a one-cycle done pulse. All outputs are registered.
module serial_xnor_comparator #(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          a,
    input  logic          b,
    output logic          busy,
    output logic          done,
    output logic          equal,
    output logic [CW-1:0] mismatches
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t        state, next_state;
    logic [IW-1:0] bit_idx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          bit_eq;
    logic          take;
    logic          last_take;

    // Per-bit equality and the running count including the bit in flight.
    always_comb begin
        bit_eq    = ~(a ^ b);
        take      = (state == COMPARE) && bit_valid;
        last_take = take && (bit_idx == LAST_IDX);
        cnt_next  = cnt + CW'(take & ~bit_eq);
    end

    // Next-state logic: COMPARE ends on the edge that accepts the last bit;
    // DONE lasts one cycle and may chain straight into the next word.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = COMPARE;
            COMPARE: if (last_take) next_state = DONE;
            DONE:    next_state = start ? COMPARE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State, datapath and registered outputs; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_idx    <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            equal      <= 1'b0;
            mismatches <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state == COMPARE);
            done  <= (next_state == DONE);
            if ((state == IDLE || state == DONE) && start) begin
                bit_idx <= '0;
                cnt     <= '0;
            end else if (take) begin
                bit_idx <= bit_idx + IW'(1);
                cnt     <= cnt_next;
            end
            // Result registers change only when a word completes.
            if (last_take) begin
                mismatches <= cnt_next;
                equal      <= (cnt_next == '0);
            end
        end
    end

endmodule
